rr_reconfig_scheduler: RTL

Sequences partial reconfiguration of NUM_RR reconfigurable regions through the single icapi engine.
- Each region presents a desired reconfigurable-module (RM) id.
- The block tracks the RM loaded in each region and round-robin arbitrates among regions whose desired RM differs.
- For the granted region it computes the bitstream address and size, pulses rc_start, and waits for rc_done.
- It isolates the region during the transfer and resets the region once the transfer completes.

---
 rtl/rr_sched_pkg.sv | 29 ++
 rtl/rr_rr_arbiter.sv | 38 +++
 rtl/rr_reconfig_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the reconfigurable-region scheduler.
// Holds the FSM encoding, the "no RM loaded" marker and the bitstream address rule.
package rr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        WAIT     = 3'd3,
        POST_RST = 3'd4
    } state_t;

    localparam int RM_ID_W_MAX = 8;
    localparam logic [RM_ID_W_MAX-1:0] RM_INVALID = {RM_ID_W_MAX{1'b1}};

    // Segments are laid out region-major: each region owns num_rm consecutive slots.
    function automatic logic [31:0] bs_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] region,
        input logic [31:0] rm,
        input logic [31:0] num_rm
    );
        logic [31:0] seg;
        seg = region * num_rm + rm;
        return base + seg * stride;
    endfunction

endpackage

// File: rtl/rr_rr_arbiter.sv
// Round-robin pick: first pending region at or after rr_ptr, wrapping around.
// Purely combinational.
module rr_rr_arbiter #(
    parameter int NUM_RR = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_RR-1:0] pending,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [IDX_W-1:0]  grant,
    output logic              any_pending
);

    // Scan offsets 0..NUM_RR-1 from the pointer; the first hit wins.
    always_comb begin : pick
        logic [IDX_W:0]   sum_v;
        logic [IDX_W-1:0] idx_v;
        grant       = {IDX_W{1'b0}};
        any_pending = 1'b0;
        sum_v       = {(IDX_W+1){1'b0}};
        idx_v       = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_RR; i++) begin
            sum_v = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum_v >= (IDX_W+1)'(NUM_RR)) begin
                sum_v = sum_v - (IDX_W+1)'(NUM_RR);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[IDX_W-1:0];
            if (!any_pending && pending[idx_v]) begin
                any_pending = 1'b1;
                grant       = idx_v;
            end else begin
                any_pending = any_pending;
            end
        end
    end

endmodule

// File: rtl/rr_reconfig_scheduler.sv
// Sequences partial reconfiguration of NUM_RR regions through one icapi engine,
// isolating each region during its transfer and resetting it afterwards.
module rr_reconfig_scheduler
    import rr_sched_pkg::*;
#(
    parameter int          NUM_RR     = 2,
    parameter int          NUM_RM     = 2,
    parameter int          RM_ID_W    = 2,
    parameter logic [31:0] BS_BASE    = 32'h0,
    parameter logic [31:0] BS_STRIDE  = 32'h20,
    parameter int          RM_SIZE    = 16,
    parameter int          HDR_SIZE   = 16,
    parameter int          RST_CYCLES = 2,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic [NUM_RR*RM_ID_W-1:0]   rm_desired,
    output logic [NUM_RR*RM_ID_W-1:0]   rm_current,
    output logic                        rc_start,
    output logic                        rc_bop,
    output logic [31:0]                 rc_baddr,
    output logic [31:0]                 rc_bsize,
    input  logic                        rc_done,
    output logic [NUM_RR-1:0]           rr_isolate,
    output logic [NUM_RR-1:0]           rr_rst,
    output logic                        busy,
    output logic                        err_timeout,
    output logic [15:0]                 cfg_count
);

    localparam int IDX_W = (NUM_RR > 1) ? $clog2(NUM_RR) : 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int PRC_W = $clog2(RST_CYCLES) + 1;
    localparam logic [RM_ID_W-1:0] RM_NONE = RM_INVALID[RM_ID_W-1:0];

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic [NUM_RR-1:0][RM_ID_W-1:0]  des_s;
    logic [NUM_RR-1:0][RM_ID_W-1:0]  cur_r;
    logic [NUM_RR-1:0]               pending_s;
    logic [NUM_RR-1:0]               iso_r;
    logic [NUM_RR-1:0]               rrst_r;
    logic [IDX_W-1:0]                g_r;
    logic [IDX_W-1:0]                g_next_s;
    logic [IDX_W-1:0]                ptr_r;
    logic [IDX_W-1:0]                grant_s;
    logic                            any_s;
    logic [RM_ID_W-1:0]              rm_r;
    logic [TMR_W-1:0]                tmr_r;
    logic [PRC_W-1:0]                prc_r;
    logic                            timeout_s;
    logic                            post_done_s;
    logic                            busy_s;
    logic                            rc_start_r;
    logic                            err_r;
    logic [31:0]                     baddr_r;
    logic [31:0]                     bsize_r;
    logic [15:0]                     cnt_r;

    assign des_s = rm_desired;

    // A region wants service when its valid desired id differs from what is loaded.
    always_comb begin
        pending_s = {NUM_RR{1'b0}};
        for (int r = 0; r < NUM_RR; r++) begin
            pending_s[r] = (des_s[r] != cur_r[r]) && (32'(des_s[r]) < 32'(NUM_RM));
        end
    end

    rr_rr_arbiter #(
        .NUM_RR (NUM_RR),
        .IDX_W  (IDX_W)
    ) u_arb (
        .pending     (pending_s),
        .rr_ptr      (ptr_r),
        .grant       (grant_s),
        .any_pending (any_s)
    );

    assign timeout_s   = (tmr_r == TMR_W'(TIMEOUT - 1));
    assign post_done_s = (prc_r == PRC_W'(RST_CYCLES - 1));
    assign g_next_s    = (g_r == IDX_W'(NUM_RR - 1)) ? {IDX_W{1'b0}} : g_r + IDX_W'(1);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; rc_done only matters while waiting on the engine.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) state_nxt_s = LOAD;
                else       state_nxt_s = IDLE;
            end
            LOAD:  state_nxt_s = START;
            START: state_nxt_s = WAIT;
            WAIT: begin
                if (rc_done)        state_nxt_s = POST_RST;
                else if (timeout_s) state_nxt_s = IDLE;
                else                state_nxt_s = WAIT;
            end
            POST_RST: begin
                if (post_done_s) state_nxt_s = IDLE;
                else             state_nxt_s = POST_RST;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = 1'b0;
            default: busy_s = 1'b1;
        endcase
    end

    // Datapath and registered outputs; grant and RM are latched on leaving IDLE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cur_r      <= {NUM_RR{RM_NONE}};
            iso_r      <= {NUM_RR{1'b1}};
            rrst_r     <= {NUM_RR{1'b1}};
            g_r        <= {IDX_W{1'b0}};
            ptr_r      <= {IDX_W{1'b0}};
            rm_r       <= {RM_ID_W{1'b0}};
            tmr_r      <= {TMR_W{1'b0}};
            prc_r      <= {PRC_W{1'b0}};
            rc_start_r <= 1'b0;
            err_r      <= 1'b0;
            baddr_r    <= 32'h0;
            bsize_r    <= 32'h0;
            cnt_r      <= 16'h0;
        end else begin
            rc_start_r <= (state_r == LOAD);
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        g_r            <= grant_s;
                        rm_r           <= des_s[grant_s];
                        baddr_r        <= bs_addr(BS_BASE, BS_STRIDE, 32'(grant_s),
                                                  32'(des_s[grant_s]), 32'(NUM_RM));
                        bsize_r        <= 32'(RM_SIZE + HDR_SIZE);
                        iso_r[grant_s] <= 1'b1;
                    end
                end
                START: tmr_r <= {TMR_W{1'b0}};
                WAIT: begin
                    if (rc_done) begin
                        cur_r[g_r]  <= rm_r;
                        cnt_r       <= cnt_r + 16'd1;
                        ptr_r       <= g_next_s;
                        rrst_r[g_r] <= 1'b1;
                        prc_r       <= {PRC_W{1'b0}};
                    end else if (timeout_s) begin
                        // Marking the region empty makes it pending again for a retry.
                        err_r       <= 1'b1;
                        cur_r[g_r]  <= RM_NONE;
                        ptr_r       <= g_next_s;
                        rrst_r[g_r] <= 1'b1;
                        iso_r[g_r]  <= 1'b1;
                    end else begin
                        tmr_r <= tmr_r + TMR_W'(1);
                    end
                end
                POST_RST: begin
                    if (post_done_s) begin
                        rrst_r[g_r] <= 1'b0;
                        iso_r[g_r]  <= 1'b0;
                    end else begin
                        prc_r <= prc_r + PRC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rm_current  = cur_r;
    assign rc_start    = rc_start_r;
    assign rc_bop      = 1'b1;
    assign rc_baddr    = baddr_r;
    assign rc_bsize    = bsize_r;
    assign rr_isolate  = iso_r;
    assign rr_rst      = rrst_r;
    assign busy        = busy_s;
    assign err_timeout = err_r;
    assign cfg_count   = cnt_r;

endmodule
